mem_access_stage: RTL and testbench

- MIPS MEM stage. Consumes the EX/MEM latch (ALU result, store data, destination register, memory/write-back control buses, branch target, flags) and drives the data-memory port through a req/ack handshake.
- Resolves conditional branches and produces the MEM/WB latch.
- Raises `stall` so upstream stages hold while a memory access is outstanding.
- Its registered ALU result is the EX-stage MEM-forwarding source.

---
 rtl/mem_access_stage.sv | 159 +++++++++++++++
 tb/tb_mem_access_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS MEM pipeline stage.
//   Takes the EX/MEM latch, runs data-memory accesses over a req/ack
//   handshake, resolves conditional branches and produces the MEM/WB latch.
//   out_alu is the EX-stage MEM-forwarding source.
// Ports:
//   clk, reset (async, active-low)
//   in_pc_branch, in_alu, in_reg2, in_write_reg, zero_flag, neg_flag  - EX/MEM latch
//   memory_bus  : [0] rd, [1] wr, [2] beq, [3] bne, [5:4] size, [6] unsigned, [7] unused
//   writeBack_bus : [0] reg_write, [1] mem_to_reg
//   dmem_req/we/addr/wdata/ack/rdata - data-memory port
//   stall, pc_src, out_pc_branch, misaligned
//   out_read_data, out_alu, out_write_reg, writeBack_bus_out - MEM/WB latch
// Byte-lane logic assumes a 32-bit datapath (four byte lanes).
module mem_access_stage #(
    parameter int len = 32,
    parameter int NB  = $clog2(len)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [len-1:0] in_pc_branch,
    input  logic [len-1:0] in_alu,
    input  logic [len-1:0] in_reg2,
    input  logic [NB-1:0]  in_write_reg,
    input  logic           zero_flag,
    input  logic           neg_flag,
    input  logic [7:0]     memory_bus,
    input  logic [1:0]     writeBack_bus,
    output logic           dmem_req,
    output logic [3:0]     dmem_we,
    output logic [len-1:0] dmem_addr,
    output logic [len-1:0] dmem_wdata,
    input  logic           dmem_ack,
    input  logic [len-1:0] dmem_rdata,
    output logic           stall,
    output logic           pc_src,
    output logic [len-1:0] out_pc_branch,
    output logic           misaligned,
    output logic [len-1:0] out_read_data,
    output logic [len-1:0] out_alu,
    output logic [NB-1:0]  out_write_reg,
    output logic [1:0]     writeBack_bus_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]     state, state_next;
    logic [len-1:0] rdata_q;
    logic [len-1:0] load_data;
    logic [3:0]     lanes;
    logic           mem_read, mem_write, is_write, mem_op;
    logic           is_byte, is_half, is_word;
    logic           mis, go, busy, sext;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic           unused_ok;

    assign unused_ok = ^{neg_flag, memory_bus[7]};

    assign mem_read  = memory_bus[0];
    assign mem_write = memory_bus[1];
    assign is_write  = mem_write & ~mem_read;   // read wins when both are set
    assign mem_op    = mem_read | mem_write;
    assign is_byte   = (memory_bus[5:4] == 2'b00);
    assign is_half   = (memory_bus[5:4] == 2'b01);
    assign is_word   = ~is_byte & ~is_half;     // 10 and 11 both mean word
    assign sext      = ~memory_bus[6];

    assign mis  = (is_half & in_alu[0]) | (is_word & (|in_alu[1:0]));
    assign go   = mem_op & ~mis;
    assign busy = ((state == IDLE) & go) | (state == WAIT);

    // Gated by reset so the request and stall drop the instant reset asserts,
    // even though upstream may still be presenting the memory op.
    assign dmem_req = reset & busy;
    assign stall    = reset & busy;

    assign pc_src        = (memory_bus[2] & zero_flag) | (memory_bus[3] & ~zero_flag);
    assign out_pc_branch = in_pc_branch;
    assign dmem_addr     = {in_alu[len-1:2], 2'b00};

    always_comb begin
        lanes      = '0;
        dmem_wdata = in_reg2;
        if (is_byte) begin
            lanes      = 4'b0001 << in_alu[1:0];
            dmem_wdata = {4{in_reg2[7:0]}};
        end else if (is_half) begin
            lanes      = 4'b0011 << {in_alu[1], 1'b0};
            dmem_wdata = {2{in_reg2[15:0]}};
        end else begin
            lanes      = 4'b1111;
        end
    end

    assign dmem_we = (is_write & dmem_req) ? lanes : 4'b0000;

    // Lane extraction works on the captured word; in_alu is held stable by
    // upstream for the whole access, so it still selects the right lane in DONE.
    always_comb begin
        rd_byte   = rdata_q[{in_alu[1:0], 3'b000} +: 8];
        rd_half   = in_alu[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_data = rdata_q;
        if (is_byte)
            load_data = {{(len-8){sext & rd_byte[7]}}, rd_byte};
        else if (is_half)
            load_data = {{(len-16){sext & rd_half[15]}}, rd_half};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = dmem_ack ? DONE : WAIT;
            WAIT:    if (dmem_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (busy && dmem_ack)
                rdata_q <= dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_read_data     <= '0;
            out_alu           <= '0;
            out_write_reg     <= '0;
            writeBack_bus_out <= '0;
            misaligned        <= 1'b0;
        end else begin
            misaligned <= (state == IDLE) & mem_op & mis;
            if (state == DONE) begin
                out_alu           <= in_alu;
                out_write_reg     <= in_write_reg;
                writeBack_bus_out <= writeBack_bus;
                out_read_data     <= mem_read ? load_data : '0;
            end else if (busy) begin
                writeBack_bus_out <= '0;
            end else begin
                // No access issued: plain ALU pass-through, or a misaligned op
                // retired as a bubble.
                out_alu           <= in_alu;
                out_write_reg     <= in_write_reg;
                writeBack_bus_out <= mem_op ? 2'b00 : writeBack_bus;
                out_read_data     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed, scoreboard-checked bench for mem_access_stage.
module tb_mem_access_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic [31:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_pc_branch, in_alu, in_reg2;
    logic [4:0]  in_write_reg;
    logic        zero_flag, neg_flag;
    logic [7:0]  memory_bus;
    logic [1:0]  writeBack_bus;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, pc_src;
    logic [31:0] out_pc_branch;
    logic        misaligned;
    logic [31:0] out_read_data, out_alu;
    logic [4:0]  out_write_reg;
    logic [1:0]  writeBack_bus_out;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    mem_access_stage #(.len(32), .NB(5)) dut (
        .clk(clk), .reset(reset),
        .in_pc_branch(in_pc_branch), .in_alu(in_alu), .in_reg2(in_reg2),
        .in_write_reg(in_write_reg), .zero_flag(zero_flag), .neg_flag(neg_flag),
        .memory_bus(memory_bus), .writeBack_bus(writeBack_bus),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .pc_src(pc_src), .out_pc_branch(out_pc_branch),
        .misaligned(misaligned), .out_read_data(out_read_data), .out_alu(out_alu),
        .out_write_reg(out_write_reg), .writeBack_bus_out(writeBack_bus_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one EX/MEM entry and record what MEM/WB must show for it.
    task automatic drive(input logic [31:0] alu, input logic [31:0] reg2,
                         input logic [31:0] pcb, input logic [4:0] wr,
                         input logic [7:0] mb, input logic [1:0] wbb,
                         input logic zf, input exp_t e);
        in_alu = alu; in_reg2 = reg2; in_pc_branch = pcb; in_write_reg = wr;
        memory_bus = mb; writeBack_bus = wbb; zero_flag = zf;
        sbq.push_back(e);
        #1;
    endtask

    // Run the entry to completion: ack after ack_at stalled cycles, then pop
    // the scoreboard once the MEM/WB latch has been written.
    task automatic complete(input int ack_at, input logic [31:0] rdata, input int exp_stall);
        int   st  = 0;
        int   cyc = 0;
        exp_t e;
        while (stall === 1'b1 && cyc < 20) begin
            st++;
            dmem_ack   = (cyc == ack_at);
            dmem_rdata = dmem_ack ? rdata : 32'hDEAD_BEEF;
            step();
            dmem_ack   = 1'b0;
            dmem_rdata = 32'hDEAD_BEEF;
            cyc++;
            if (stall === 1'b1) chk("bubble_wb", {30'd0, writeBack_bus_out}, 32'd0);
        end
        chk("stall_cycles", st, exp_stall);
        step();
        memory_bus = 8'h00; writeBack_bus = 2'b00;
        chk("sb_depth", sbq.size(), 1);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("out_alu", out_alu, e.alu);
            chk("out_write_reg", {27'd0, out_write_reg}, {27'd0, e.wr});
            chk("wb_out", {30'd0, writeBack_bus_out}, {30'd0, e.wb});
            chk("out_read_data", out_read_data, e.rd);
        end
    endtask

    initial begin
        reset = 1'b1;
        in_pc_branch = '0; in_alu = '0; in_reg2 = '0; in_write_reg = '0;
        zero_flag = 1'b0; neg_flag = 1'b0; memory_bus = '0; writeBack_bus = '0;
        dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
        #3 reset = 1'b0;
        step(); step();
        chk("rst_out_alu", out_alu, 32'd0);
        chk("rst_wb_out", {30'd0, writeBack_bus_out}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        reset = 1'b1;
        step();

        // ALU op, no memory access
        drive(32'h1234, 32'h0, 32'h0, 5'd5, 8'h00, 2'b01, 1'b0, '{32'h1234, 5'd5, 2'b01, 32'd0});
        chk("alu_stall", {31'd0, stall}, 32'd0);
        complete(0, 32'h0, 0);

        // lb at 0x103, ack on the third WAIT cycle
        drive(32'h103, 32'h0, 32'h0, 5'd8, 8'h01, 2'b11, 1'b0, '{32'h103, 5'd8, 2'b11, 32'hFFFF_FF80});
        chk("lb_req", {31'd0, dmem_req}, 32'd1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we", {28'd0, dmem_we}, 32'd0);
        complete(3, 32'h80FF_0000, 4);

        // lhu at 0x102, ack together with the request
        drive(32'h102, 32'h0, 32'h0, 5'd10, 8'h51, 2'b11, 1'b0, '{32'h102, 5'd10, 2'b11, 32'h0000_8001});
        complete(0, 32'h8001_0000, 1);

        // lh at 0x102
        drive(32'h102, 32'h0, 32'h0, 5'd11, 8'h11, 2'b11, 1'b0, '{32'h102, 5'd11, 2'b11, 32'hFFFF_8001});
        complete(0, 32'h8001_0000, 1);

        // sb at 0x201
        drive(32'h201, 32'hAABB_CCDD, 32'h0, 5'd0, 8'h02, 2'b00, 1'b0, '{32'h201, 5'd0, 2'b00, 32'd0});
        chk("sb_we", {28'd0, dmem_we}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
        chk("sb_addr", dmem_addr, 32'h200);
        complete(1, 32'h0, 2);

        // sh at 0x202
        drive(32'h202, 32'hAABB_CCDD, 32'h0, 5'd0, 8'h12, 2'b00, 1'b0, '{32'h202, 5'd0, 2'b00, 32'd0});
        chk("sh_we", {28'd0, dmem_we}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hCCDD_CCDD);
        complete(0, 32'h0, 1);

        // sw at 0x200
        drive(32'h200, 32'hAABB_CCDD, 32'h0, 5'd0, 8'h32, 2'b00, 1'b0, '{32'h200, 5'd0, 2'b00, 32'd0});
        chk("sw_we", {28'd0, dmem_we}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hAABB_CCDD);
        complete(0, 32'h0, 1);

        // Misaligned lw at 0x202: no request, bubble, one-cycle flag
        drive(32'h202, 32'h0, 32'h0, 5'd12, 8'h31, 2'b11, 1'b0, '{32'h202, 5'd12, 2'b00, 32'd0});
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        complete(0, 32'h0, 0);
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        step();
        chk("mis_clear", {31'd0, misaligned}, 32'd0);

        // Branches
        drive(32'h0, 32'h0, 32'h0000_4000, 5'd0, 8'h04, 2'b00, 1'b1, '{32'h0, 5'd0, 2'b00, 32'd0});
        chk("beq_taken", {31'd0, pc_src}, 32'd1);
        chk("pc_branch", out_pc_branch, 32'h0000_4000);
        complete(0, 32'h0, 0);
        drive(32'h0, 32'h0, 32'h0000_5000, 5'd0, 8'h08, 2'b00, 1'b1, '{32'h0, 5'd0, 2'b00, 32'd0});
        chk("bne_not_taken", {31'd0, pc_src}, 32'd0);
        complete(0, 32'h0, 0);

        // Reset asserted while waiting for an ack
        in_alu = 32'h300; in_write_reg = 5'd9; memory_bus = 8'h31; writeBack_bus = 2'b11;
        #1;
        chk("abort_req_before", {31'd0, dmem_req}, 32'd1);
        step();
        chk("abort_wait_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_req", {31'd0, dmem_req}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_out_alu", out_alu, 32'd0);
        chk("abort_wb_out", {30'd0, writeBack_bus_out}, 32'd0);
        memory_bus = 8'h00; writeBack_bus = 2'b00; in_alu = 32'h0; in_write_reg = 5'd0;
        step();
        reset = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
        step();
        dmem_ack = 1'b0; dmem_rdata = 32'hDEAD_BEEF;
        chk("stray_stall", {31'd0, stall}, 32'd0);
        chk("stray_req", {31'd0, dmem_req}, 32'd0);
        chk("stray_rdata", out_read_data, 32'd0);
        chk("stray_wb", {30'd0, writeBack_bus_out}, 32'd0);

        // Next lw completes normally
        drive(32'h300, 32'h0, 32'h0, 5'd9, 8'h31, 2'b11, 1'b0, '{32'h300, 5'd9, 2'b11, 32'h1234_5678});
        chk("lw_addr", dmem_addr, 32'h300);
        complete(1, 32'h1234_5678, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
